// File: rtl/ram_read_arbiter.sv
// Two-port read sequencer for the shared VGA character/pixel RAM (port 0 = pixel fetch, port 1 = host).
// Latency: handshake in C, mem_oe in C+1..C+READ_LAT, rsp_valid in C+READ_LAT+1; one read per READ_LAT+2 cycles.
// Backpressure: reqN_ready only in IDLE for the granted port; responses are never stalled. RAM_READ_ARBITER_RR_EN selects round-robin.
module ram_read_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int WORD_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [WORD_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    input  logic [WORD_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              cnt_done;
    logic              id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              grant_id;
    logic              any_valid;
    logic              hs;

    assign any_valid = req0_valid | req1_valid;

`ifdef RAM_READ_ARBITER_RR_EN
    logic last_id;

    // When both ports contend, the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            last_id <= 1'b0;
        end else if (hs) begin
            last_id <= grant_id;
        end
    end
`else
    assign grant_id = ~req0_valid;
`endif

    assign req0_ready = (state == ST_IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == ST_IDLE) && req1_valid &&  grant_id;
    assign hs         = (state == ST_IDLE) && any_valid;
    assign cnt_done   = (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (hs) state_nxt = ST_ACCESS;
            ST_ACCESS: if (cnt_done) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address and ID are only loaded on a handshake, so mem_addr is frozen for the whole access.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            addr_q <= '0;
            id_q   <= 1'b0;
            cnt    <= 4'd0;
            data_q <= '0;
        end else begin
            if (hs) begin
                addr_q <= grant_id ? req1_addr : req0_addr;
                id_q   <= grant_id;
                cnt    <= 4'(READ_LAT - 1);
            end else if (state == ST_ACCESS) begin
                if (cnt_done) begin
                    data_q <= mem_data;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    // Decoded straight from the state register so reset drops mem_oe without waiting for a clock.
    assign mem_oe    = (state == ST_ACCESS);
    assign mem_addr  = addr_q;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule
